// File: rtl/pulse_gate_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pulse_gate_pkg
// Purpose  : Shared types and default sizing for the pulse gate-window
//            controller (state encoding, gate/count widths, settle time).
// Revision : 1.0 - initial release
// ============================================================================
package pulse_gate_pkg;

    // Controller states. The width is pinned so the encoding never changes
    // silently if a state is added later.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GATE    = 2'd1,
        ST_DRAIN   = 2'd2,
        ST_CAPTURE = 2'd3
    } gate_state_t;

    localparam int C_GATE_W     = 24;
    localparam int C_CNT_W      = 16;
    localparam int C_SETTLE_CYC = 2;

endpackage : pulse_gate_pkg
`default_nettype wire

// File: rtl/pulse_gate_ctrl_gate_timer.sv
`default_nettype none
// ============================================================================
// Module   : gate_timer
// Purpose  : Loadable down-counter that times both the counting window and
//            the settle interval. Counts down by one per clock and stops at 0.
// Ports    : clk, rst        - clock, asynchronous active-high reset
//            load            - load load_value this cycle (wins over counting)
//            load_value      - value to load
//            value           - current count
//            last            - value == 1, i.e. this is the final cycle
// Revision : 1.0 - initial release
// ============================================================================
module gate_timer #(
    parameter int GATE_W = 24
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [GATE_W-1:0] load_value,
    output logic [GATE_W-1:0] value,
    output logic              last
);

    logic [GATE_W-1:0] r_value;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_value <= '0;
        end else if (load) begin
            r_value <= load_value;
        end else if (r_value != '0) begin
            r_value <= r_value - GATE_W'(1);
        end
    end

    assign value = r_value;
    assign last  = (r_value == GATE_W'(1));

endmodule : gate_timer
`default_nettype wire

// File: rtl/pulse_gate_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pulse_gate_ctrl
// Purpose  : Gate-window controller for the pulse edge counter. Opens a
//            window of gate_cycles clocks (0 treated as 1), lets the counter
//            pipeline settle, then reports count(end) - count(start) modulo
//            2^CNT_W over a valid/ready handshake.
// Ports    : clk, rst        - clock, asynchronous active-high reset
//            start           - begin a measurement (only honoured in IDLE)
//            continuous      - re-arm after each result (latched per window)
//            abort           - cancel immediately, back to IDLE
//            gate_cycles     - window length in clocks
//            count           - counter value
//            en_count        - counter enable
//            busy            - not IDLE
//            result          - edges counted in the last window
//            result_valid    - result held
//            result_ready    - consumer accepts result
//            overrun         - sticky: a held result was overwritten
// Revision : 1.0 - initial release
// ============================================================================
module pulse_gate_ctrl
    import pulse_gate_pkg::*;
#(
    parameter int GATE_W     = C_GATE_W,
    parameter int CNT_W      = C_CNT_W,
    parameter int SETTLE_CYC = C_SETTLE_CYC
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              continuous,
    input  logic              abort,
    input  logic [GATE_W-1:0] gate_cycles,
    input  logic [CNT_W-1:0]  count,
    output logic              en_count,
    output logic              busy,
    output logic [CNT_W-1:0]  result,
    output logic              result_valid,
    input  logic              result_ready,
    output logic              overrun
);

    localparam logic [GATE_W-1:0] C_SETTLE_LOAD = GATE_W'(SETTLE_CYC);

    gate_state_t       r_state;
    gate_state_t       w_state_nxt;
    logic              r_en_count;
    logic              r_busy;
    logic              r_cont;
    logic [CNT_W-1:0]  r_count_start;
    logic [CNT_W-1:0]  r_result;
    logic              r_result_valid;
    logic              r_overrun;

    logic              w_tmr_load;
    logic [GATE_W-1:0] w_tmr_load_value;
    logic [GATE_W-1:0] w_tmr_value;
    logic              w_tmr_last;
    logic [GATE_W-1:0] w_gate_len;
    logic              w_tmr_done;
    logic              w_capture;
    logic              w_accept;
    logic              w_arm;

    // A zero-length window still enables the counter for one clock.
    assign w_gate_len = (gate_cycles == '0) ? GATE_W'(1) : gate_cycles;

    // An already-empty timer also ends the interval so the FSM can never stall.
    assign w_tmr_done = w_tmr_last || (w_tmr_value == '0);

    gate_timer #(
        .GATE_W (GATE_W)
    ) u_gate_timer (
        .clk        (clk),
        .rst        (rst),
        .load       (w_tmr_load),
        .load_value (w_tmr_load_value),
        .value      (w_tmr_value),
        .last       (w_tmr_last)
    );

    // Next state and timer reload. abort overrides every transition.
    always_comb begin
        w_state_nxt      = r_state;
        w_tmr_load       = 1'b0;
        w_tmr_load_value = w_gate_len;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = ST_GATE;
                    w_tmr_load  = 1'b1;
                end
            end
            ST_GATE: begin
                if (w_tmr_done) begin
                    // With no settle time the end snapshot follows directly.
                    w_state_nxt      = (SETTLE_CYC == 0) ? ST_CAPTURE : ST_DRAIN;
                    w_tmr_load       = 1'b1;
                    w_tmr_load_value = C_SETTLE_LOAD;
                end
            end
            ST_DRAIN: begin
                if (w_tmr_done) begin
                    w_state_nxt = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                if (r_cont) begin
                    w_state_nxt = ST_GATE;
                    w_tmr_load  = 1'b1;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
        if (abort) begin
            w_state_nxt      = ST_IDLE;
            w_tmr_load       = 1'b1;
            w_tmr_load_value = '0;
        end
    end

    // Window opens from IDLE, result lands in CAPTURE (unless aborted).
    assign w_arm     = (r_state == ST_IDLE) && start && !abort;
    assign w_capture = (r_state == ST_CAPTURE) && !abort;
    assign w_accept  = r_result_valid && result_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= ST_IDLE;
            r_en_count     <= 1'b0;
            r_busy         <= 1'b0;
            r_cont         <= 1'b0;
            r_count_start  <= '0;
            r_result       <= '0;
            r_result_valid <= 1'b0;
            r_overrun      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_en_count <= (w_state_nxt == ST_GATE);
            r_busy     <= (w_state_nxt != ST_IDLE);

            if (w_arm) begin
                r_count_start <= count;
                r_cont        <= continuous;
                r_overrun     <= 1'b0;
            end

            if (w_capture) begin
                // Modulo subtraction makes a counter wrap inside the window
                // transparent.
                r_result       <= count - r_count_start;
                r_result_valid <= 1'b1;
                // A simultaneous accept consumes the old result, so it is
                // not lost.
                if (r_result_valid && !result_ready) begin
                    r_overrun <= 1'b1;
                end
                if (r_cont) begin
                    r_count_start <= count;
                    r_cont        <= continuous;
                end
            end else if (w_accept) begin
                r_result_valid <= 1'b0;
            end
        end
    end

    assign en_count     = r_en_count;
    assign busy         = r_busy;
    assign result       = r_result;
    assign result_valid = r_result_valid;
    assign overrun      = r_overrun;

endmodule : pulse_gate_ctrl
`default_nettype wire
